// File: rtl/product_bcd_pkg.sv
// -----------------------------------------------------------------------------
// product_bcd_pkg
// Shared definitions for the signed-product to BCD converter:
//   - WIDTH_DEF / DIGITS_DEF : default product width and BCD digit count
//   - state_t                : converter FSM state encoding
// -----------------------------------------------------------------------------
package product_bcd_pkg;

   localparam int WIDTH_DEF  = 16;
   localparam int DIGITS_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added, so the following left shift carries into the next digit
// exactly when the doubled value would reach 10.
// Ports:
//   digit    : input  [3:0]  scratch digit before correction
//   adjusted : output [3:0]  corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/product_bcd_conv.sv
// -----------------------------------------------------------------------------
// product_bcd_conv
// Converts a two's-complement product to sign + packed BCD magnitude using a
// sequential double-dabble, one bit per clock.
// Ports:
//   Clk       : input             system clock, rising edge
//   Reset_n   : input             synchronous active-low reset
//   start_i   : input             request a conversion (sampled in IDLE only)
//   product_i : input  [WIDTH-1]  two's-complement product, sampled at start
//   busy_o    : output            high while shifting
//   done_o    : output            one-cycle pulse when neg_o/bcd_o update
//   neg_o     : output            sign of the last converted product
//   bcd_o     : output [4*DIGITS] packed BCD magnitude, MSD at the top
// Timing: start edge E0, shifts on E1..E(WIDTH), result and done_o registered
// at E(WIDTH), DONE lasts one cycle, then back to IDLE.
// -----------------------------------------------------------------------------
module product_bcd_conv
   import product_bcd_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      product_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  neg_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int BW  = 4 * DIGITS;
   localparam int TOT = BW + WIDTH;
   localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t              state_reg,   state_next;
   logic [BW-1:0]       scratch_reg, scratch_next;
   logic [WIDTH-1:0]    mag_reg,     mag_next;
   logic [CW-1:0]       cnt_reg,     cnt_next;
   logic                neg_reg,     neg_next;
   logic [BW-1:0]       bcd_reg,     bcd_next;
   logic                neg_out_reg, neg_out_next;
   logic                busy_reg,    busy_next;
   logic                done_reg,    done_next;

   logic [BW-1:0]       adj_scratch;
   logic [TOT-1:0]      shift_vec;
   logic [TOT-1:0]      shifted;
   logic [WIDTH-1:0]    abs_product;

   // Per-digit add-3 correction applied before every shift.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit    (scratch_reg[4*gi +: 4]),
            .adjusted (adj_scratch[4*gi +: 4])
         );
      end
   endgenerate

   // scratch:mag shifted left as one vector; the magnitude MSB feeds digit 0.
   assign shift_vec = {adj_scratch, mag_reg};
   assign shifted   = shift_vec << 1;

   // Unsigned negation of the most negative value yields 2^(WIDTH-1), which
   // is exactly its magnitude when read as unsigned.
   assign abs_product = product_i[WIDTH-1] ? (-product_i) : product_i;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_reg   <= ST_IDLE;
         scratch_reg <= '0;
         mag_reg     <= '0;
         cnt_reg     <= '0;
         neg_reg     <= 1'b0;
         bcd_reg     <= '0;
         neg_out_reg <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         scratch_reg <= scratch_next;
         mag_reg     <= mag_next;
         cnt_reg     <= cnt_next;
         neg_reg     <= neg_next;
         bcd_reg     <= bcd_next;
         neg_out_reg <= neg_out_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      scratch_next = scratch_reg;
      mag_next     = mag_reg;
      cnt_next     = cnt_reg;
      neg_next     = neg_reg;
      bcd_next     = bcd_reg;
      neg_out_next = neg_out_reg;
      busy_next    = 1'b0;
      done_next    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               neg_next     = product_i[WIDTH-1];
               mag_next     = abs_product;
               scratch_next = '0;
               cnt_next     = '0;
               busy_next    = 1'b1;
               state_next   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            scratch_next = shifted[TOT-1:WIDTH];
            mag_next     = shifted[WIDTH-1:0];
            if (cnt_reg == CW'(WIDTH - 1)) begin
               // Last shift: publish the freshly shifted scratch directly.
               cnt_next     = '0;
               bcd_next     = shifted[TOT-1:WIDTH];
               neg_out_next = neg_reg;
               done_next    = 1'b1;
               state_next   = ST_DONE;
            end else begin
               cnt_next  = cnt_reg + CW'(1);
               busy_next = 1'b1;
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign busy_o = busy_reg;
   assign done_o = done_reg;
   assign neg_o  = neg_out_reg;
   assign bcd_o  = bcd_reg;

endmodule

// File: tb/tb_product_bcd_conv.sv
module tb_product_bcd_conv;

   typedef struct packed {
      logic        neg;
      logic [19:0] bcd;
   } exp_t;

   logic        Clk;
   logic        Reset_n;
   logic        start_i;
   logic [15:0] product_i;
   logic        busy_o;
   logic        done_o;
   logic        neg_o;
   logic [19:0] bcd_o;

   int   total = 0;
   int   bad   = 0;
   int   done_count = 0;
   exp_t exp_q[$];
   logic        prev_neg = 1'b0;
   logic [19:0] prev_bcd = 20'h0;

   product_bcd_conv dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .start_i   (start_i),
      .product_i (product_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .neg_o     (neg_o),
      .bcd_o     (bcd_o)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Monitor: pops one expectation per done_o pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (done_o === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done with bcd=%0h neg=%0b required no done", bcd_o, neg_o);
            end else begin
               e = exp_q.pop_front();
               check("result_bcd", 32'(bcd_o), 32'(e.bcd));
               check("result_neg", 32'(neg_o), 32'(e.neg));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One conversion with latency, hold-while-busy and pulse-width checks.
   task automatic run_conv(input logic [15:0] v, input logic n, input logic [19:0] b);
      int  cyc;
      bit  got;
      exp_t e;
      @(negedge Clk);
      product_i = v;
      start_i   = 1'b1;
      e.neg = n;
      e.bcd = b;
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
      start_i = 1'b0;
      check("busy_after_start", 32'(busy_o), 32'd1);
      cyc = 0;
      got = 0;
      while (!got && cyc < 40) begin
         @(posedge Clk);
         cyc++;
         #1;
         if (done_o) got = 1;
         else if (cyc == 8) begin
            check("hold_bcd", 32'(bcd_o), 32'(prev_bcd));
            check("hold_neg", 32'(neg_o), 32'(prev_neg));
            check("busy_mid", 32'(busy_o), 32'd1);
         end
      end
      check("latency", 32'(cyc), 32'd16);
      check("busy_in_done", 32'(busy_o), 32'd0);
      @(posedge Clk);
      #1;
      check("done_one_cycle", 32'(done_o), 32'd0);
      prev_neg = n;
      prev_bcd = b;
   endtask

   initial begin
      int          dc;
      int          hits[$];
      exp_t        e;
      int          cyc;
      Reset_n   = 1'b0;
      start_i   = 1'b0;
      product_i = 16'h0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_done", 32'(done_o), 32'd0);
      check("reset_neg",  32'(neg_o),  32'd0);
      check("reset_bcd",  32'(bcd_o),  32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      run_conv(16'h0019, 1'b0, 20'h00025);
      run_conv(16'hFFFF, 1'b1, 20'h00001);
      run_conv(16'h7FFF, 1'b0, 20'h32767);
      run_conv(16'h8000, 1'b1, 20'h32768);

      // Input change and restart request during SHIFT are ignored.
      dc = done_count;
      @(negedge Clk);
      product_i = 16'h1234;
      start_i   = 1'b1;
      e.neg = 1'b0;
      e.bcd = 20'h04660;
      exp_q.push_back(e);
      @(negedge Clk);
      start_i = 1'b0;
      repeat (4) @(negedge Clk);
      product_i = 16'hFFF0;
      start_i   = 1'b1;
      @(negedge Clk);
      start_i = 1'b0;
      product_i = 16'h0001;
      repeat (30) @(negedge Clk);
      check("one_done_on_restart", 32'(done_count - dc), 32'd1);
      prev_neg = 1'b0;
      prev_bcd = 20'h04660;

      // Reset at SHIFT cycle 8 abandons conversion; reset beats start_i.
      dc = done_count;
      @(negedge Clk);
      product_i = 16'h0100;
      start_i   = 1'b1;
      @(negedge Clk);
      start_i = 1'b0;
      repeat (7) @(negedge Clk);
      Reset_n   = 1'b0;
      start_i   = 1'b1;
      product_i = 16'h0005;
      @(posedge Clk);
      #1;
      check("rst_mid_busy", 32'(busy_o), 32'd0);
      check("rst_mid_done", 32'(done_o), 32'd0);
      check("rst_mid_neg",  32'(neg_o),  32'd0);
      check("rst_mid_bcd",  32'(bcd_o),  32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      start_i = 1'b0;
      repeat (25) @(negedge Clk);
      check("no_done_after_rst", 32'(done_count - dc), 32'd0);
      prev_neg = 1'b0;
      prev_bcd = 20'h0;
      run_conv(16'hFF85, 1'b1, 20'h00123);

      // start_i held high with zero input: one result every 18 cycles.
      e.neg = 1'b0;
      e.bcd = 20'h0;
      repeat (3) exp_q.push_back(e);
      @(negedge Clk);
      product_i = 16'h0000;
      start_i   = 1'b1;
      @(posedge Clk);
      cyc = 0;
      while (hits.size() < 3 && cyc < 80) begin
         @(posedge Clk);
         cyc++;
         #1;
         if (done_o) hits.push_back(cyc);
      end
      start_i = 1'b0;
      check("held_done_count", 32'(hits.size()), 32'd3);
      if (hits.size() == 3) begin
         check("held_first",   32'(hits[0]), 32'd16);
         check("held_period1", 32'(hits[1] - hits[0]), 32'd18);
         check("held_period2", 32'(hits[2] - hits[1]), 32'd18);
      end
      repeat (25) @(negedge Clk);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
